// File: rtl/grid_move_sequencer.sv
// Command sequencer ahead of the 4x4-step grid walker. Move commands enter
// through a valid/ready FIFO and leave as single-cycle moves on direction/steps.
// A command is issued rep+1 times. steps is 0 whenever nothing is issued.
//
// state | meaning
// IDLE  | nothing issuing; pops the FIFO head when entries exist and hold is low
// ISSUE | a command is active; repeats it, chains the next one, or drains to IDLE
module grid_move_sequencer #(
    parameter int DEPTH = 4,
    parameter int REP_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_dir,
    input  logic [1:0]                 in_steps,
    input  logic [REP_W-1:0]           in_rep,
    input  logic                       hold,
    output logic [1:0]                 direction,
    output logic [1:0]                 steps,
    output logic                       move_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drain_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 4 + REP_W;

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, empty, push, pop;

    state_t           state, state_nx;
    logic [REP_W-1:0] remaining, rem_nx;
    logic [1:0]       cur_dir, cur_dir_nx, cur_steps, cur_steps_nx;
    logic [1:0]       dir_nx, steps_nx;
    logic             mv_nx, dd_nx;

    logic [1:0]       head_dir, head_steps;
    logic [REP_W-1:0] head_rep;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = rst_n & ~full;
    assign push     = in_valid & in_ready;
    assign level    = count;
    assign {head_dir, head_steps, head_rep} = mem[rd_ptr];

    // FIFO pointers and occupancy; a full FIFO never accepts, even alongside a pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_dir, in_steps, in_rep};
    end

    // Next state and next registered outputs; a pop loads and issues in the same edge
    always_comb begin
        state_nx     = state;
        rem_nx       = remaining;
        cur_dir_nx   = cur_dir;
        cur_steps_nx = cur_steps;
        dir_nx       = direction;
        steps_nx     = 2'b00;
        mv_nx        = 1'b0;
        dd_nx        = 1'b0;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                if (!hold && !empty) pop = 1'b1;
            end
            ISSUE: begin
                if (!hold) begin
                    if (remaining != '0) begin
                        rem_nx   = remaining - REP_W'(1);
                        dir_nx   = cur_dir;
                        steps_nx = cur_steps;
                        mv_nx    = 1'b1;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        dd_nx    = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (pop) begin
            cur_dir_nx   = head_dir;
            cur_steps_nx = head_steps;
            rem_nx       = head_rep;
            dir_nx       = head_dir;
            steps_nx     = head_steps;
            mv_nx        = 1'b1;
            state_nx     = ISSUE;
        end
    end

    // State, active command and registered outputs; reset drops any partial command
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            cur_dir    <= 2'b00;
            cur_steps  <= 2'b00;
            direction  <= 2'b00;
            steps      <= 2'b00;
            move_valid <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            state      <= state_nx;
            remaining  <= rem_nx;
            cur_dir    <= cur_dir_nx;
            cur_steps  <= cur_steps_nx;
            direction  <= dir_nx;
            steps      <= steps_nx;
            move_valid <= mv_nx;
            drain_done <= dd_nx;
        end
    end

endmodule

// File: doc/grid_move_sequencer.md
Name: grid_move_sequencer

Overview:
- Upstream command stage for the 4x4-step grid walker, which updates outx/outy on every clk edge from direction/steps.
- Accepts move commands through a valid/ready handshake and buffers them in a small FIFO.
- Issues each command as one or more single-cycle moves on direction/steps.
- Drives steps=0 whenever it has nothing to issue, so the walker holds position.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- REP_W, 3, width of the per-command repeat field.

Ports:
- clk  input  1  rising-edge clock, shared with the grid walker
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  command present
- in_ready  output  1  sequencer can accept a command
- in_dir  input  2  00 east, 01 west, 10 north, 11 south
- in_steps  input  2  steps per move, 0-3
- in_rep  input  REP_W  extra repetitions; the command issues in_rep+1 moves
- hold  input  1  pause issuing
- direction  output  2  to walker direction
- steps  output  2  to walker steps
- move_valid  output  1  high in cycles where direction/steps carry an issued move
- level  output  log2(DEPTH)+1  FIFO occupancy
- drain_done  output  1  one-cycle pulse when the sequencer goes idle

Behaviour:
- Reset: on a posedge clk with rst_n=0, all of the following take effect.
  - FIFO empty, level=0, state IDLE, remaining=0.
  - direction=00, steps=00, move_valid=0, drain_done=0.
  - in_ready is 0 while rst_n=0.
  - Reset mid-issue discards the current command and all queued entries; no partial move is emitted after the reset edge.
- Handshake:
  - in_ready = rst_n and not full. It is combinational from registered state.
  - A command is accepted on an edge where in_valid and in_ready are both 1.
  - No accept while full, even if a pop happens in the same cycle.
  - Accept and pop in the same cycle are allowed when not full; level is unchanged in that case.
- FIFO: stores {dir, steps, rep}. Pointers wrap modulo DEPTH. level is 0..DEPTH.
- Outputs: direction, steps, move_valid and drain_done are all registered.
- State IDLE:
  - Outputs steps=00, move_valid=0. direction holds its last value.
  - On an edge with FIFO non-empty (as of the start of the cycle), pop the head and load remaining=rep.
  - On that same edge, drive direction/steps from the popped entry with move_valid=1, and go to ISSUE.
  - Minimum latency from accept edge E to the first move on outputs is edge E+1; there is no bypass.
- State ISSUE, each edge:
  - If hold=1: next steps=00, move_valid=0, remaining unchanged, state unchanged.
  - Else if remaining>0: re-drive the current dir/steps, move_valid=1, remaining -= 1.
  - Else, with the FIFO non-empty: pop the next entry and drive it the same edge (back-to-back, no bubble).
  - Else, with the FIFO empty: steps=00, move_valid=0, drain_done=1 for one cycle, go to IDLE.
- Hold:
  - hold is sampled at the edge and takes effect on the next outputs.
  - In IDLE, hold suppresses the pop (stays IDLE).
  - Releasing hold resumes exactly where issue left off.
- in_steps=0: still issued for rep+1 cycles with move_valid=1, as a dwell with no motion.
- Boundary behaviour:
  - A full FIFO with continuous in_valid loses no command.
  - Saturation at the grid edge is the walker's job; the sequencer does not track position.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → in_ready=0, level=0, steps=0, move_valid=0. Release reset → in_ready=1.
- Single command: push {dir=00, steps=3, rep=2} at edge 1.
  - Expected: edges 2, 3, 4 show direction=00, steps=3, move_valid=1.
  - Edge 5: steps=0, drain_done=1 for one cycle.
  - Walker outx goes 3, 6, 9.
- Back-to-back: push {10,1,0}, {01,2,1}, {11,3,0} on consecutive edges.
  - Expected issue sequence: (10,1), (01,2), (01,2), (11,3) with no idle cycle between them.
  - One drain_done after the last move.
- Full FIFO: DEPTH=4, hold=1, push 5 commands.
  - Expected: in_ready drops after the 4th accept, level=4, 5th command waits.
  - After hold=0 and the first pop, the 5th is accepted and all 5 are issued in order.
- Hold mid-command: push {00,2,3}, assert hold for 2 cycles after the 2nd move.
  - Expected: moves, then two cycles of steps=0 / move_valid=0, then the remaining 2 moves. 4 moves total.
- Reset mid-issue: push {10,3,7}, drop rst_n after 3 moves.
  - Expected: next edge steps=0, level=0, no further moves, no drain_done pulse.
